// File: rtl/alu_result_stage.sv
// EX/MEM register stage behind the 32-bit ALU: beq resolution,
// overflow/illegal-op traps with EPC/cause, valid/ready on both sides.
module alu_result_stage #(
  parameter logic [4:0] OVF_CAUSE = 5'd12,
  parameter logic [4:0] RI_CAUSE  = 5'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_sum,
  input  logic        alu_zout,
  input  logic        alu_overflow,
  input  logic [2:0]  gin,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm,
  input  logic        branch,
  input  logic        ovf_check,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] store_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        exc_req,
  input  logic        exc_ack,
  output logic [31:0] epc,
  output logic [4:0]  cause
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [31:0] br_target;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        br_taken;
  } ex_mem_t;

  state_e      state_q, state_d;
  ex_mem_t     bund_q, bund_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;

  logic        legal;
  logic        addsub;
  logic        ovf_trap;
  logic        ill_trap;
  logic        xfer;
  logic        pop;
  logic        trap;
  ex_mem_t     bund_in;

  always_comb begin
    legal  = 1'b0;
    addsub = 1'b0;
    unique case (gin)
      3'b010,
      3'b110: begin
        legal  = 1'b1;
        addsub = 1'b1;
      end
      3'b111,
      3'b000,
      3'b001: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign ill_trap = ~legal;
  assign ovf_trap = ovf_check & alu_overflow & addsub;

  assign xfer = in_valid & in_ready;
  assign pop  = valid_q & out_ready;
  assign trap = xfer & (ill_trap | ovf_trap);

  always_comb begin
    bund_in            = '0;
    bund_in.result     = alu_sum;
    bund_in.store_data = store_data;
    bund_in.br_target  = pc_plus4 + (imm << 2);
    bund_in.rd         = rd;
    bund_in.reg_write  = reg_write;
    bund_in.mem_read   = mem_read;
    bund_in.mem_write  = mem_write;
    bund_in.br_taken   = branch & alu_zout;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (trap) state_d = TRAP;
      TRAP: if (exc_ack) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == RUN) & ~flush
             & (~valid_q | out_ready);
  end

  always_comb begin
    valid_d = valid_q;
    bund_d  = bund_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (xfer) begin
      valid_d = ~trap;
      if (!trap) begin
        bund_d = bund_in;
      end
    end
    if (flush) begin
      valid_d = 1'b0;
    end
    // A stale taken flag must never outlive its bundle.
    bund_d.br_taken = bund_d.br_taken & valid_d;
  end

  always_comb begin
    exc_d   = exc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    if ((state_q == TRAP) && exc_ack) begin
      exc_d = 1'b0;
    end
    if (trap) begin
      exc_d   = 1'b1;
      epc_d   = pc_plus4 - 32'd4;
      cause_d = ill_trap ? RI_CAUSE : OVF_CAUSE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bund_q  <= '0;
      exc_q   <= 1'b0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      valid_q <= valid_d;
      bund_q  <= bund_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = bund_q.result;
  assign out_store_data = bund_q.store_data;
  assign out_rd         = bund_q.rd;
  assign out_reg_write  = bund_q.reg_write;
  assign out_mem_read   = bund_q.mem_read;
  assign out_mem_write  = bund_q.mem_write;
  assign br_taken       = bund_q.br_taken;
  assign br_target      = bund_q.br_target;
  assign exc_req        = exc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered EX/MEM stage directly downstream of the 32-bit ALU; consumes its result, zero flag and overflow flag together with the instruction's control fields.
- Resolves beq branches and computes branch targets.
- Detects arithmetic-overflow and illegal-ALU-control exceptions, captures EPC/cause, and holds the pipeline until the exception is acknowledged.
- Uses a valid/ready handshake on both sides so the memory stage can stall it.

Parameters:
- OVF_CAUSE, 5'd12, cause code loaded on trapping add/sub overflow.
- RI_CAUSE, 5'd10, cause code loaded when gin is not one of 010/110/111/000/001.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream holds a valid ALU result and control bundle.
- in_ready  out  1  stage accepts the bundle this cycle.
- alu_sum  in  32  ALU result.
- alu_zout  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- gin  in  3  ALU control code used to produce alu_sum.
- pc_plus4  in  32  PC of the instruction plus 4.
- imm  in  32  sign-extended immediate (word offset).
- branch  in  1  instruction is beq.
- ovf_check  in  1  instruction traps on overflow (add/sub; 0 for addu/subu).
- rd  in  5  destination register.
- reg_write, mem_read, mem_write  in  1 each  control bits.
- store_data  in  32  rt value for stores.
- flush  in  1  synchronous kill of the output register and the current input.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- out_result, out_store_data  out  32 each  registered alu_sum and store_data.
- out_rd  out  5; out_reg_write, out_mem_read, out_mem_write  out  1 each.
- br_taken  out  1  registered: branch & alu_zout.
- br_target  out  32  registered: pc_plus4 + (imm << 2), modulo 2^32.
- exc_req  out  1  exception pending (level).
- exc_ack  in  1  exception handler acknowledges.
- epc  out  32  pc_plus4 - 4 of the trapping instruction.
- cause  out  5  exception cause.

Behaviour:
- Reset (async, rst_n=0):
  - State RUN.
  - out_valid, br_taken, exc_req = 0.
  - All data outputs, epc and cause = 0.
- States: RUN, TRAP.
- in_ready = (state==RUN) & ~flush & (~out_valid | out_ready). It is combinational and does not depend on in_valid.
- Transfer occurs when in_valid & in_ready. Latency is 1 cycle: fields appear on out_* at the next edge.
- Output pop occurs when out_valid & out_ready with no transfer; out_valid then goes 0.
- Trap condition, evaluated on transfer:
  - Overflow trap when ovf_check & alu_overflow & (gin==010 | gin==110).
  - Illegal trap when gin not in {010,110,111,000,001}. Illegal takes priority over overflow.
  - alu_overflow is ignored for all other gin values.
- On a trapping transfer:
  - out_valid <= 0; the instruction is dropped and not forwarded.
  - epc <= pc_plus4 - 4; cause <= RI_CAUSE or OVF_CAUSE.
  - exc_req <= 1; state <= TRAP.
- TRAP state:
  - in_ready = 0.
  - A pending output may still drain via out_ready.
  - On exc_ack: exc_req <= 0 and state <= RUN at the next edge. epc and cause hold until the next trap.
  - exc_ack in RUN is ignored.
- Non-trapping transfer:
  - All out_* fields are loaded.
  - br_taken = branch & alu_zout; br_target is always computed, even when not taken.
- Flush:
  - out_valid <= 0 and br_taken <= 0.
  - No transfer that cycle; flush wins over in_valid.
  - Does not leave TRAP and does not clear exc_req, epc or cause.
- Simultaneous pop and transfer: the new bundle replaces the old one in the same edge, sustaining 1 result/cycle.
- Reset mid-TRAP or mid-stall returns to the reset values immediately.

Test Plan:
- add, gin=010, a=0x7FFFFFFF result alu_sum=0x80000000, alu_overflow=1, ovf_check=1, pc_plus4=0x00400024 -> next cycle: exc_req=1, epc=0x00400020, cause=12, out_valid=0, in_ready=0; exc_ack one cycle -> exc_req=0, in_ready=1.
- Same inputs with ovf_check=0 (addu) -> out_valid=1, out_result=0x80000000, exc_req stays 0.
- beq: gin=110, alu_zout=1, branch=1, pc_plus4=0x00000010, imm=0xFFFFFFFC -> br_taken=1, br_target=0x00000000 (wrap); with alu_zout=0 -> br_taken=0.
- gin=011 with in_valid -> cause=10, exc_req=1, no output.
- Back-to-back transfers with out_ready held 0 -> first bundle held, in_ready=0; raise out_ready -> one bundle per cycle, no loss or duplication.
- flush asserted together with in_valid -> no capture, out_valid=0; assert rst_n=0 while in TRAP -> exc_req=0, state RUN, epc=0.
